mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequences the single external memory port between instruction-cache line refills and data-cache line reads and writebacks. It sits behind the fetch and data caches, accepts line-granular requests, and grants them round-robin. It runs each grant as a BEATS-long burst on the memory port and returns per-beat data plus a completion pulse. While an IC refill is outstanding, the fetch stage stalls on ic_hit low.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, memory beat width
- BEATS, 4, beats per cache line (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ic_req  in  1  IC refill request; level, held until ic_done or ic_flush
- ic_addr  in  ADDR_W  IC miss address; low bits ignored (line-aligned internally)
- ic_flush  in  1  fetch redirect; cancels or squashes the IC request
- dc_req  in  1  DC request; level, held until dc_done
- dc_we  in  1  1 = writeback, 0 = line read; stable while dc_req
- dc_addr  in  ADDR_W  DC line address
- dc_wdata  in  DATA_W  write data for beat dc_beat, supplied combinationally
- mem_ack  in  1  beat accepted/returned this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_req, mem_we  out  1  registered burst request / write
- mem_addr  out  ADDR_W  registered beat address
- mem_wdata  out  DATA_W  = dc_wdata while in DC_WR, else 0
- ic_rvalid, ic_done  out  1  registered beat-valid / line-complete pulses
- ic_rdata  out  DATA_W ; ic_beat  out  log2(BEATS)  beat data/index
- dc_rvalid, dc_done  out  1 ; dc_rdata  out  DATA_W ; dc_beat  out  log2(BEATS)
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, IC_XFER, DC_RD, DC_WR.
- IDLE arbitration uses last_gnt (reset = DC).
  - Only one requester pending: grant it.
  - Both pending: grant the one not equal to last_gnt.
  - ic_req is not eligible in a cycle where ic_flush = 1.
  - Grant updates last_gnt.
- Base address = addr with the low log2(BEATS·DATA_W/8) bits zeroed, captured at grant. Beat address = base + beat·DATA_W/8; the beat counter wraps to 0 after BEATS−1.
- A beat completes on a cycle with mem_req & mem_ack; mem_ack while mem_req = 0 is ignored. After the last beat's ack, return to IDLE.
- Reads: mem_rdata is registered into x_rdata, and x_rvalid/x_beat pulse one cycle after each ack.
- Writes: each ack advances dc_beat; no rvalid.
- x_done pulses once, the cycle after the final ack. It is simultaneous with the last rvalid and with the first IDLE cycle.
- ic_flush:
  - In IDLE: the pending IC request is dropped for that cycle.
  - During IC_XFER: the burst always completes on the bus (no abort). A sticky squash flag suppresses all later ic_rvalid and ic_done for that burst and clears on return to IDLE.
- Reset mid-burst: immediately IDLE with all outputs 0, counter 0, last_gnt = DC, squash = 0. The memory side must tolerate the dropped burst.

## Timing
- Reset values: every output 0.
- Request seen in IDLE at cycle t → mem_req = 1 with beat-0 address at t+1.
- mem_req stays high across all beats. mem_addr updates the cycle after each ack.
- Back-to-back acks give 1 beat/cycle. Zero-wait burst: t+1..t+BEATS acks, done at t+BEATS+1.
- Minimum one IDLE cycle between bursts (turnaround). A request held through done is re-arbitrated in that IDLE cycle.
- dc_beat is valid throughout DC_WR; mem_wdata follows it combinationally.

## Structure
- Shared cpu package: state encoding localparams, LINE_OFF_W = log2(BEATS·DATA_W/8), requester ID constants (GNT_IC, GNT_DC).
- One sub-module: arb_rr2, the two-input round-robin picker (req vector, last_gnt → one-hot grant). The FSM, beat counter and address generator stay in mem_arbiter.

## Test plan
- IC refill: ic_addr = 0x0000_1234, ack every cycle.
  - mem_addr = 0x1230, 0x1234, 0x1238, 0x123C.
  - ic_rvalid with ic_beat 0..3 carries the mem_rdata values.
  - ic_done at t+5.
- Simultaneous ic_req and dc_req (read) from reset: IC served first, then DC after one IDLE cycle. Repeat with both held: grants alternate.
- DC writeback 0x8000 with 2 wait cycles per beat: mem_we = 1 throughout; mem_wdata matches dc_wdata for dc_beat 0..3; dc_done once; no dc_rvalid.
- ic_flush during beat 1 of an IC refill: all 4 beats complete on the bus; no ic_rvalid after the flush and no ic_done; busy drops after beat 3.
- mem_ack pulsed in IDLE: no state or output change.
- rst_n low during beat 2 of a DC read: outputs 0 asynchronously. After release, a fresh ic_req is granted with beat 0 at the correct address.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, requester IDs,
// and line-geometry helper.
package mem_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_IC_XFER = 2'd1;
  localparam state_t ST_DC_RD   = 2'd2;
  localparam state_t ST_DC_WR   = 2'd3;

  // last_gnt encoding and bit positions in the request/grant vectors
  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;
  localparam int   REQ_IC = 0;
  localparam int   REQ_DC = 1;

  // LINE_OFF_W: byte-offset bits within one cache line
  function automatic int line_off_w(input int beats, input int data_w);
    return $clog2(beats * data_w / 8);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// External memory port: burst request/address/write data out, ack/read data back.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time.
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o         = '0;
      gnt_o[REQ_IC] = (last_gnt_i == GNT_DC);
      gnt_o[REQ_DC] = (last_gnt_i == GNT_IC);
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Sequences the single memory port between IC refills and DC line reads /
// writebacks as BEATS-long bursts with per-beat return data and done pulses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ic_req_i,
  input  logic [ADDR_W-1:0]          ic_addr_i,
  input  logic                       ic_flush_i,
  input  logic                       dc_req_i,
  input  logic                       dc_we_i,
  input  logic [ADDR_W-1:0]          dc_addr_i,
  input  logic [DATA_W-1:0]          dc_wdata_i,
  mem_arbiter_if.master              mem,
  output logic                       ic_rvalid_o,
  output logic                       ic_done_o,
  output logic [DATA_W-1:0]          ic_rdata_o,
  output logic [$clog2(BEATS)-1:0]   ic_beat_o,
  output logic                       dc_rvalid_o,
  output logic                       dc_done_o,
  output logic [DATA_W-1:0]          dc_rdata_o,
  output logic [$clog2(BEATS)-1:0]   dc_beat_o,
  output logic                       busy_o
);
  localparam int                BW         = $clog2(BEATS);
  localparam int                OFF_W      = line_off_w(BEATS, DATA_W);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);
  localparam logic [BW-1:0]     LAST_BEAT  = BW'(BEATS - 1);

  state_t            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              squash_q, squash_d;
  logic              ic_rvalid_q, ic_done_q, dc_rvalid_q, dc_done_q;
  logic [DATA_W-1:0] ic_rdata_q, dc_rdata_q;
  logic [BW-1:0]     ic_beat_q, dc_rbeat_q;

  logic [1:0] req_vec, gnt;
  logic       beat_ack, last_beat, squash_live;
  logic       ic_rv_d, ic_done_d, dc_rv_d, dc_done_d;
  logic       unused_lsbs;

  assign unused_lsbs = ^{ic_addr_i[OFF_W-1:0], dc_addr_i[OFF_W-1:0]};

  // A flushing fetch stage is not a candidate this cycle.
  assign req_vec[REQ_IC] = ic_req_i & ~ic_flush_i;
  assign req_vec[REQ_DC] = dc_req_i;

  arb_rr2 u_arb (
    .req_i      (req_vec),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt)
  );

  assign beat_ack    = (state_q != ST_IDLE) & mem.mem_ack;
  assign last_beat   = (cnt_q == LAST_BEAT);
  assign squash_live = squash_q | ic_flush_i;

  assign ic_rv_d   = beat_ack & (state_q == ST_IC_XFER) & ~squash_live;
  assign ic_done_d = ic_rv_d & last_beat;
  assign dc_rv_d   = beat_ack & (state_q == ST_DC_RD);
  assign dc_done_d = beat_ack & last_beat & ((state_q == ST_DC_RD) | (state_q == ST_DC_WR));
  // Squash survives until the (unabortable) burst drains back to IDLE.
  assign squash_d  = (state_q == ST_IC_XFER) & squash_live & ~(beat_ack & last_beat);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    if (state_q == ST_IDLE) begin
      if (gnt[REQ_IC]) begin
        state_d    = ST_IC_XFER;
        last_gnt_d = GNT_IC;
        cnt_d      = '0;
        addr_d     = {ic_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end else if (gnt[REQ_DC]) begin
        state_d    = dc_we_i ? ST_DC_WR : ST_DC_RD;
        last_gnt_d = GNT_DC;
        cnt_d      = '0;
        addr_d     = {dc_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end
    end else if (beat_ack) begin
      cnt_d  = cnt_q + 1'b1;
      addr_d = last_beat ? '0 : addr_q + BEAT_BYTES;
      if (last_beat) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= GNT_DC;
      cnt_q       <= '0;
      addr_q      <= '0;
      squash_q    <= 1'b0;
      ic_rvalid_q <= 1'b0;
      ic_done_q   <= 1'b0;
      dc_rvalid_q <= 1'b0;
      dc_done_q   <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_beat_q   <= '0;
      dc_rbeat_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      squash_q    <= squash_d;
      ic_rvalid_q <= ic_rv_d;
      ic_done_q   <= ic_done_d;
      dc_rvalid_q <= dc_rv_d;
      dc_done_q   <= dc_done_d;
      if (ic_rv_d) ic_rdata_q <= mem.mem_rdata;
      if (dc_rv_d) dc_rdata_q <= mem.mem_rdata;
      ic_beat_q   <= ic_rv_d ? cnt_q : '0;
      dc_rbeat_q  <= dc_rv_d ? cnt_q : '0;
    end
  end

  assign mem.mem_req   = (state_q != ST_IDLE);
  assign mem.mem_we    = (state_q == ST_DC_WR);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = (state_q == ST_DC_WR) ? dc_wdata_i : '0;

  assign ic_rvalid_o = ic_rvalid_q;
  assign ic_done_o   = ic_done_q;
  assign ic_rdata_o  = ic_rdata_q;
  assign ic_beat_o   = ic_beat_q;
  assign dc_rvalid_o = dc_rvalid_q;
  assign dc_done_o   = dc_done_q;
  assign dc_rdata_o  = dc_rdata_q;
  // Writebacks expose the live beat so the cache can source dc_wdata for it.
  assign dc_beat_o   = (state_q == ST_DC_WR) ? cnt_q : dc_rbeat_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed sequences, an arbitration
// vector table, and a randomized run against a burst-level reference model.
module tb_mem_arbiter;
  localparam int BEATS = 4;

  logic        clk, rst_n;
  logic        ic_req, ic_flush, dc_req, dc_we;
  logic [31:0] ic_addr, dc_addr, dc_wdata;
  logic        ic_rvalid, ic_done, dc_rvalid, dc_done, busy;
  logic [31:0] ic_rdata, dc_rdata;
  logic [1:0]  ic_beat, dc_beat;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  function automatic logic [31:0] wpat(input logic [31:0] a, input logic [1:0] b);
    return {a[15:0], 14'h2A5, b};
  endfunction

  assign dc_wdata = wpat(dc_addr, dc_beat);

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BEATS(BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_flush_i(ic_flush),
    .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
    .mem(mif),
    .ic_rvalid_o(ic_rvalid), .ic_done_o(ic_done), .ic_rdata_o(ic_rdata), .ic_beat_o(ic_beat),
    .dc_rvalid_o(dc_rvalid), .dc_done_o(dc_done), .dc_rdata_o(dc_rdata), .dc_beat_o(dc_beat),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);          chk({tag, ".mem_req"}, mif.mem_req, 0);
    chk({tag, ".mem_we"}, mif.mem_we, 0);  chk({tag, ".mem_addr"}, mif.mem_addr, 0);
    chk({tag, ".mem_wdata"}, mif.mem_wdata, 0);
    chk({tag, ".ic_rvalid"}, ic_rvalid, 0); chk({tag, ".ic_done"}, ic_done, 0);
    chk({tag, ".ic_rdata"}, ic_rdata, 0);   chk({tag, ".ic_beat"}, ic_beat, 0);
    chk({tag, ".dc_rvalid"}, dc_rvalid, 0); chk({tag, ".dc_done"}, dc_done, 0);
    chk({tag, ".dc_rdata"}, dc_rdata, 0);   chk({tag, ".dc_beat"}, dc_beat, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ic_req = 0; ic_flush = 0; dc_req = 0; dc_we = 0; ic_addr = 0; dc_addr = 0;
    mif.mem_ack = 0; mif.mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- burst-level reference model ----------------
  int          m_own, m_beat, m_last;   // owner: 0 none, 1 IC, 2 DC
  bit          m_wr, m_sq;
  logic [31:0] m_base, e_rdata;
  int          e_beat;
  bit          e_icrv, e_icdone, e_dcrv, e_dcdone;

  task automatic model_step();
    int g;
    e_icrv = 0; e_icdone = 0; e_dcrv = 0; e_dcdone = 0;
    if (m_own == 0) begin
      g = 0;
      if ((ic_req && !ic_flush) && dc_req) g = (m_last == 2) ? 1 : 2;
      else if (ic_req && !ic_flush)        g = 1;
      else if (dc_req)                     g = 2;
      if (g != 0) begin
        m_own = g; m_last = g; m_beat = 0; m_sq = 0;
        m_base = ((g == 1) ? ic_addr : dc_addr) & ~32'hF;
        m_wr = (g == 2) && dc_we;
      end
    end else begin
      if (m_own == 1 && ic_flush) m_sq = 1;
      if (mif.mem_ack) begin
        if (m_own == 1 && !m_sq) begin e_icrv = 1; e_rdata = mif.mem_rdata; e_beat = m_beat; end
        if (m_own == 2 && !m_wr) begin e_dcrv = 1; e_rdata = mif.mem_rdata; e_beat = m_beat; end
        if (m_beat == BEATS - 1) begin
          if (m_own == 1 && !m_sq) e_icdone = 1;
          if (m_own == 2)          e_dcdone = 1;
          m_own = 0;
        end else m_beat++;
      end
    end
  endtask

  typedef struct {
    bit ic; bit fl; bit dc; bit we; int own;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 0, 1, 0, 1};  tbl[1] = '{1, 0, 1, 0, 2};
    tbl[2] = '{1, 0, 1, 0, 1};  tbl[3] = '{0, 0, 1, 1, 2};
    tbl[4] = '{1, 1, 0, 0, 0};  tbl[5] = '{1, 1, 1, 0, 2};
    tbl[6] = '{1, 0, 0, 0, 1};  tbl[7] = '{1, 0, 1, 0, 2};
    tbl[8] = '{0, 0, 0, 0, 0};  tbl[9] = '{1, 0, 1, 0, 1};

    do_reset();
    chk_zero("reset");

    // IC refill at 0x1234, zero wait
    ic_req = 1; ic_addr = 32'h0000_1234;
    step();
    for (int b = 0; b < BEATS; b++) begin
      chk("ic.mem_req", mif.mem_req, 1);
      chk("ic.mem_addr", mif.mem_addr, 32'h1230 + 4 * b);
      chk("ic.busy", busy, 1);
      chk("ic.done_early", ic_done, 0);
      if (b > 0) begin
        chk("ic.rvalid", ic_rvalid, 1);
        chk("ic.beat", ic_beat, b - 1);
        chk("ic.rdata", ic_rdata, 32'hD000_0000 + b - 1);
      end
      mif.mem_ack = 1; mif.mem_rdata = 32'hD000_0000 + b;
      step();
    end
    mif.mem_ack = 0;
    chk("ic.last_rvalid", ic_rvalid, 1); chk("ic.last_beat", ic_beat, 3);
    chk("ic.last_rdata", ic_rdata, 32'hD000_0003);
    chk("ic.done", ic_done, 1); chk("ic.idle_at_done", busy, 0);
    ic_req = 0;
    step();
    chk("ic.done_once", ic_done, 0); chk("ic.mem_req_off", mif.mem_req, 0);

    // Simultaneous IC + DC read from reset: IC first, DC after one IDLE cycle
    do_reset();
    ic_req = 1; ic_addr = 32'h1234; dc_req = 1; dc_we = 0; dc_addr = 32'h8040;
    mif.mem_rdata = 32'hBEEF_0003;
    step();
    chk("both.first_addr", mif.mem_addr, 32'h1230); chk("both.first_we", mif.mem_we, 0);
    mif.mem_ack = 1;
    repeat (BEATS) step();
    chk("both.ic_done", ic_done, 1); chk("both.turnaround", busy, 0);
    chk("both.no_dc_rv", dc_rvalid, 0);
    ic_req = 0; mif.mem_ack = 0;
    step();
    chk("both.dc_req", mif.mem_req, 1); chk("both.dc_addr", mif.mem_addr, 32'h8040);
    mif.mem_ack = 1;
    repeat (BEATS) step();
    chk("both.dc_done", dc_done, 1); chk("both.dc_rvalid", dc_rvalid, 1);
    chk("both.dc_beat", dc_beat, 3); chk("both.dc_rdata", dc_rdata, 32'hBEEF_0003);
    dc_req = 0; mif.mem_ack = 0;
    step();
    chk("both.idle", busy, 0);

    // DC writeback at 0x8000, two wait cycles per beat
    dc_req = 1; dc_we = 1; dc_addr = 32'h8000;
    step();
    for (int b = 0; b < BEATS; b++) begin
      for (int w = 0; w < 3; w++) begin
        chk("wb.mem_we", mif.mem_we, 1); chk("wb.mem_req", mif.mem_req, 1);
        chk("wb.dc_beat", dc_beat, b);
        chk("wb.mem_addr", mif.mem_addr, 32'h8000 + 4 * b);
        chk("wb.mem_wdata", mif.mem_wdata, wpat(32'h8000, 2'(b)));
        chk("wb.no_rvalid", dc_rvalid, 0); chk("wb.no_done", dc_done, 0);
        mif.mem_ack = (w == 2);
        step();
      end
    end
    mif.mem_ack = 0;
    chk("wb.done", dc_done, 1); chk("wb.no_rvalid_end", dc_rvalid, 0);
    chk("wb.idle", busy, 0); chk("wb.wdata_idle", mif.mem_wdata, 0);
    dc_req = 0;
    step();
    chk("wb.done_once", dc_done, 0);

    // ic_flush during beat 1 of an IC refill
    ic_req = 1; ic_addr = 32'h2000;
    step();
    chk("fl.beat0", mif.mem_addr, 32'h2000);
    mif.mem_ack = 1;
    step();
    chk("fl.rv0", ic_rvalid, 1); chk("fl.beat1", mif.mem_addr, 32'h2004);
    ic_flush = 1; ic_req = 0; mif.mem_ack = 0;
    step();
    ic_flush = 0;
    chk("fl.rv_after", ic_rvalid, 0); chk("fl.busy", busy, 1);
    for (int k = 1; k < BEATS; k++) begin
      chk("fl.addr", mif.mem_addr, 32'h2000 + 4 * k); chk("fl.req", mif.mem_req, 1);
      chk("fl.no_rv", ic_rvalid, 0); chk("fl.no_done", ic_done, 0);
      mif.mem_ack = 1;
      step();
    end
    mif.mem_ack = 0;
    chk("fl.busy_drop", busy, 0); chk("fl.no_rv_end", ic_rvalid, 0);
    chk("fl.no_done_end", ic_done, 0);
    step();
    chk("fl.no_done_late", ic_done, 0); chk("fl.no_rv_late", ic_rvalid, 0);

    // mem_ack in IDLE is ignored
    do_reset();
    mif.mem_ack = 1; mif.mem_rdata = 32'hFFFF_FFFF;
    step();
    chk_zero("idle_ack");
    mif.mem_ack = 0; ic_req = 1; ic_addr = 32'h3008;
    step();
    chk("idle_ack.beat0", mif.mem_addr, 32'h3000); chk("idle_ack.req", mif.mem_req, 1);
    mif.mem_ack = 1;
    repeat (BEATS) step();
    chk("idle_ack.done", ic_done, 1);
    ic_req = 0; mif.mem_ack = 0;
    step();

    // async reset during beat 2 of a DC read
    dc_req = 1; dc_we = 0; dc_addr = 32'h4000; mif.mem_rdata = 32'h1111_2222;
    step();
    chk("rst.beat0", mif.mem_addr, 32'h4000);
    mif.mem_ack = 1;
    repeat (2) step();
    chk("rst.beat2", mif.mem_addr, 32'h4008);
    mif.mem_ack = 0;
    #2 rst_n = 0;
    #1 chk_zero("async_rst");
    dc_req = 0;
    @(negedge clk) rst_n = 1;
    step();
    ic_req = 1; ic_addr = 32'h5554;
    step();
    chk("rst.ic_addr", mif.mem_addr, 32'h5550); chk("rst.ic_req", mif.mem_req, 1);
    chk("rst.ic_we", mif.mem_we, 0);
    mif.mem_ack = 1;
    repeat (BEATS) step();
    chk("rst.ic_done", ic_done, 1);
    ic_req = 0; mif.mem_ack = 0;
    step();

    // arbitration vector table (last_gnt carries from one row to the next)
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ic_req = tbl[i].ic; ic_flush = tbl[i].fl; dc_req = tbl[i].dc; dc_we = tbl[i].we;
      ic_addr = 32'h1234; dc_addr = 32'h801C;
      step();
      ic_req = 0; ic_flush = 0; dc_req = 0;
      chk("tbl.mem_req", mif.mem_req, tbl[i].own != 0);
      if (tbl[i].own != 0) begin
        chk("tbl.addr", mif.mem_addr, (tbl[i].own == 1) ? 32'h1230 : 32'h8010);
        chk("tbl.we", mif.mem_we, (tbl[i].own == 2) && tbl[i].we);
        mif.mem_ack = 1;
        repeat (BEATS) step();
        mif.mem_ack = 0;
        chk("tbl.ic_done", ic_done, tbl[i].own == 1);
        chk("tbl.dc_done", dc_done, tbl[i].own == 2);
        step();
      end else chk("tbl.busy", busy, 0);
    end

    // randomized traffic against the reference model
    do_reset();
    m_own = 0; m_last = 2; m_beat = 0; m_wr = 0; m_sq = 0; m_base = 0;
    e_icrv = 0; e_icdone = 0; e_dcrv = 0; e_dcdone = 0; e_rdata = 0; e_beat = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk("rnd.busy", busy, m_own != 0);
      chk("rnd.mem_req", mif.mem_req, m_own != 0);
      if (m_own != 0) begin
        chk("rnd.addr", mif.mem_addr, m_base + 32'(4 * m_beat));
        chk("rnd.we", mif.mem_we, m_wr);
      end
      if (m_own == 2 && m_wr) begin
        chk("rnd.wbeat", dc_beat, m_beat);
        chk("rnd.wdata", mif.mem_wdata, wpat(dc_addr, 2'(m_beat)));
      end else chk("rnd.wdata0", mif.mem_wdata, 0);
      chk("rnd.ic_rvalid", ic_rvalid, e_icrv); chk("rnd.ic_done", ic_done, e_icdone);
      chk("rnd.dc_rvalid", dc_rvalid, e_dcrv); chk("rnd.dc_done", dc_done, e_dcdone);
      if (e_icrv) begin chk("rnd.ic_rdata", ic_rdata, e_rdata); chk("rnd.ic_beat", ic_beat, e_beat); end
      if (e_dcrv) begin chk("rnd.dc_rdata", dc_rdata, e_rdata); chk("rnd.dc_beat", dc_beat, e_beat); end

      if (e_icdone) ic_req = 0;
      ic_flush = ($urandom_range(0, 15) == 0);
      if (ic_flush && m_own == 1) ic_req = 0;
      if (!ic_req && !ic_flush && $urandom_range(0, 3) == 0) begin
        ic_req = 1; ic_addr = $urandom;
      end
      if (e_dcdone) dc_req = 0;
      if (!dc_req && $urandom_range(0, 3) == 0) begin
        dc_req = 1; dc_we = $urandom_range(0, 1) == 1; dc_addr = $urandom;
      end
      mif.mem_ack   = ($urandom_range(0, 2) != 0);
      mif.mem_rdata = $urandom;
      model_step();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
